// File: rtl/uart_tx_fifo_if.sv
// Bus/transmitter-side signal bundle for the UART transmit FIFO.
// Latency: none (wires only).
// Backpressure: none in the bundle; the FIFO drops pushes while full and flags overflow.
// Ports: wr_en/wr_data/flush/clr_ovf in, full/empty/count/overflow status out,
//        tx_start/tx_data launch out, tx_busy/tx_end transmitter status in.
interface uart_tx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              flush;
   logic              clr_ovf;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              tx_end;

   // master: bus/CSR side plus the transmitter model driving status back
   modport master (
      output wr_en, wr_data, flush, clr_ovf, tx_busy, tx_end,
      input  full, empty, count, overflow, tx_start, tx_data
   );

   // slave: the FIFO/sequencer itself
   modport slave (
      input  wr_en, wr_data, flush, clr_ovf, tx_busy, tx_end,
      output full, empty, count, overflow, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter one character at a time.
// Latency: byte pushed at edge k into an idle, empty FIFO launches (tx_start) after edge k+1.
// Backpressure: no ready; pushes while full are dropped and latch the sticky overflow flag.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries push/flush/clr_ovf in,
//        full/empty/count/overflow out, tx_start/tx_data out, tx_busy/tx_end in.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus
);
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_END  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q;
   logic              tx_start_q;
   logic [7:0]        tx_data_q;
   logic              full_w;
   logic              empty_w;
   logic              launch;
   logic              push_ok;
   logic              ovf_set;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   // A launch pops in the same cycle, so a push while full still fits.
   // flush wins over both push and pop.
   assign push_ok = bus.wr_en && !bus.flush && (!full_w || launch);
   assign ovf_set = bus.wr_en && !bus.flush && full_w && !launch;

   // ---------------- sequencer: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- sequencer: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (launch)      state_d = WAIT_BUSY;
         WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_END;
         WAIT_END:  if (bus.tx_end)  state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // ---------------- sequencer: outputs ----------------
   // No fall-through: launch looks at the registered count only.
   always_comb begin
      launch = (state_q == IDLE) && !empty_w && !bus.flush;
   end

   // tx_start is a registered one-cycle pulse; tx_data holds until the next launch.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         tx_start_q <= launch;
         if (launch) tx_data_q <= mem[rd_ptr];
      end
   end

   // ---------------- storage ----------------
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (launch)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, launch})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow; a new drop in the clearing cycle keeps it set.
   always_ff @(posedge clk) begin
      if (rst)               overflow_q <= 1'b0;
      else if (ovf_set)      overflow_q <= 1'b1;
      else if (bus.clr_ovf)  overflow_q <= 1'b0;
   end

   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
endmodule
